// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter between the CPU MEM stage and the NIC.
package dmem_arb_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W     = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CPU_LD = 2'd1,
        NIC_LD = 2'd2
    } state_t;

    // Starvation counter width; never zero even when STARVE_MAX is 0.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// CPU, NIC and data-memory signals of the arbiter; master = requesters/memory side, slave = arbiter.
interface dmem_arbiter_if #(
    parameter int ADDR_W = dmem_arb_pkg::ADDR_W_DEF
);
    import dmem_arb_pkg::*;

    logic              cpu_memEn;
    logic              cpu_memwrEn;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_stall;
    logic [DATA_W-1:0] cpu_rdata;

    logic              nic_req;
    logic              nic_wr;
    logic [ADDR_W-1:0] nic_addr;
    logic [DATA_W-1:0] nic_wdata;
    logic              nic_gnt;
    logic              nic_rvalid;
    logic [DATA_W-1:0] nic_rdata;

    logic              dmem_en;
    logic              dmem_wrEn;
    logic [ADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_din;
    logic [DATA_W-1:0] dmem_dout;

    modport master (
        output cpu_memEn, cpu_memwrEn, cpu_addr, cpu_wdata,
        output nic_req, nic_wr, nic_addr, nic_wdata,
        output dmem_dout,
        input  cpu_stall, cpu_rdata, nic_gnt, nic_rvalid, nic_rdata,
        input  dmem_en, dmem_wrEn, dmem_addr, dmem_din
    );

    modport slave (
        input  cpu_memEn, cpu_memwrEn, cpu_addr, cpu_wdata,
        input  nic_req, nic_wr, nic_addr, nic_wdata,
        input  dmem_dout,
        output cpu_stall, cpu_rdata, nic_gnt, nic_rvalid, nic_rdata,
        output dmem_en, dmem_wrEn, dmem_addr, dmem_din
    );

endinterface

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter: CPU has priority, NIC wins after STARVE_MAX refused cycles.
module dmem_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int ADDR_W     = dmem_arb_pkg::ADDR_W_DEF
) (
    input  logic          clk,
    input  logic          reset,
    dmem_arbiter_if.slave bus
);
    import dmem_arb_pkg::*;

    localparam int               CNT_W      = cnt_width(STARVE_MAX);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    state_t            r_state;
    state_t            w_state_next;
    logic [CNT_W-1:0]  r_starve_cnt;
    logic [CNT_W-1:0]  w_starve_next;
    logic              w_nic_win;
    logic [ADDR_W-1:0] w_addr;

    assign bus.dmem_addr = w_addr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_starve_cnt <= '0;
        end else begin
            r_state      <= w_state_next;
            r_starve_cnt <= w_starve_next;
        end
    end

    // Outputs are gated by reset so they drop the instant reset rises.
    always_comb begin
        w_state_next   = r_state;
        w_nic_win      = 1'b0;
        w_addr         = '0;
        bus.dmem_en    = 1'b0;
        bus.dmem_wrEn  = 1'b0;
        bus.dmem_din   = '0;
        bus.cpu_stall  = 1'b0;
        bus.cpu_rdata  = '0;
        bus.nic_gnt    = 1'b0;
        bus.nic_rvalid = 1'b0;
        bus.nic_rdata  = '0;
        if (!reset) begin
            unique case (r_state)
                IDLE: begin
                    w_nic_win = bus.nic_req && (!bus.cpu_memEn || r_starve_cnt == STARVE_LIM);
                    if (w_nic_win) begin
                        bus.dmem_en   = 1'b1;
                        bus.dmem_wrEn = bus.nic_wr;
                        w_addr        = bus.nic_addr;
                        bus.dmem_din  = bus.nic_wdata;
                        bus.nic_gnt   = 1'b1;
                        bus.cpu_stall = bus.cpu_memEn;
                        if (!bus.nic_wr) w_state_next = NIC_LD;
                    end else if (bus.cpu_memEn) begin
                        bus.dmem_en   = 1'b1;
                        bus.dmem_wrEn = bus.cpu_memwrEn;
                        w_addr        = bus.cpu_addr;
                        bus.dmem_din  = bus.cpu_wdata;
                        bus.cpu_stall = !bus.cpu_memwrEn;
                        if (!bus.cpu_memwrEn) w_state_next = CPU_LD;
                    end
                end
                CPU_LD: begin
                    // The still-held CPU request is the one being completed, not a new one.
                    bus.cpu_rdata = bus.dmem_dout;
                    w_state_next  = IDLE;
                end
                NIC_LD: begin
                    bus.nic_rvalid = 1'b1;
                    bus.nic_rdata  = bus.dmem_dout;
                    bus.cpu_stall  = bus.cpu_memEn;
                    w_state_next   = IDLE;
                end
                default: w_state_next = IDLE;
            endcase
        end

        if (!bus.nic_req || w_nic_win) begin
            w_starve_next = '0;
        end else if (r_starve_cnt != STARVE_LIM) begin
            w_starve_next = r_starve_cnt + 1'b1;
        end else begin
            w_starve_next = r_starve_cnt;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed vector table plus starvation and async-reset sequences for dmem_arbiter.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int AW = 32;

    typedef logic [228:0] obs_t;

    typedef struct {
        logic        cen;
        logic        cwr;
        logic [31:0] caddr;
        logic [63:0] cwd;
        logic        nreq;
        logic        nwr;
        logic [31:0] naddr;
        logic [63:0] nwd;
        obs_t        exp;
    } vec_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   passed = 0;
    int   total  = 0;

    logic [63:0] mem [0:255];
    vec_t        vecs [15];

    dmem_arbiter_if #(.ADDR_W(AW)) bus ();

    dmem_arbiter #(.STARVE_MAX(4), .ADDR_W(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Memory model: write lands at the issuing edge, read data appears the cycle after.
    always @(posedge clk) begin
        if (bus.dmem_en) begin
            if (bus.dmem_wrEn) mem[bus.dmem_addr[7:0]] <= bus.dmem_din;
            else               bus.dmem_dout <= mem[bus.dmem_addr[7:0]];
        end
    end

    function automatic obs_t mk(input logic st, input logic [63:0] crd, input logic g,
                                input logic rv, input logic [63:0] nrd, input logic en,
                                input logic wr, input logic [31:0] a, input logic [63:0] d);
        return {st, crd, g, rv, nrd, en, wr, a, d};
    endfunction

    function automatic vec_t mkv(input logic cen, input logic cwr, input logic [31:0] caddr,
                                 input logic [63:0] cwd, input logic nreq, input logic nwr,
                                 input logic [31:0] naddr, input logic [63:0] nwd, input obs_t exp);
        vec_t v;
        v.cen = cen; v.cwr = cwr; v.caddr = caddr; v.cwd = cwd;
        v.nreq = nreq; v.nwr = nwr; v.naddr = naddr; v.nwd = nwd; v.exp = exp;
        return v;
    endfunction

    function automatic obs_t observe();
        return mk(bus.cpu_stall, bus.cpu_rdata, bus.nic_gnt, bus.nic_rvalid, bus.nic_rdata,
                  bus.dmem_en, bus.dmem_wrEn, bus.dmem_addr, bus.dmem_din);
    endfunction

    task automatic drive(input logic cen, input logic cwr, input logic [31:0] caddr,
                         input logic [63:0] cwd, input logic nreq, input logic nwr,
                         input logic [31:0] naddr, input logic [63:0] nwd);
        bus.cpu_memEn   = cen;
        bus.cpu_memwrEn = cwr;
        bus.cpu_addr    = caddr;
        bus.cpu_wdata   = cwd;
        bus.nic_req     = nreq;
        bus.nic_wr      = nwr;
        bus.nic_addr    = naddr;
        bus.nic_wdata   = nwd;
    endtask

    task automatic check(input string nm, input obs_t exp);
        obs_t act;
        act = observe();
        total++;
        if (act === exp) begin
            passed++;
            $display("ok   %s obs=%h", nm, act);
        end else begin
            $display("FAIL %s got=%h expected=%h", nm, act, exp);
        end
    endtask

    initial begin
        obs_t z;
        int   s;
        z = '0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        bus.dmem_dout = '0;

        vecs[0]  = mkv(0,0,0,0,             0,0,0,0,        z);
        vecs[1]  = mkv(1,1,'h10,'hDEADBEEF, 0,0,0,0,        mk(0,0,0,0,0,1,1,'h10,'hDEADBEEF));
        vecs[2]  = mkv(1,0,'h10,0,          0,0,0,0,        mk(1,0,0,0,0,1,0,'h10,0));
        vecs[3]  = mkv(1,0,'h10,0,          0,0,0,0,        mk(0,'hDEADBEEF,0,0,0,0,0,0,0));
        vecs[4]  = mkv(0,0,0,0,             1,1,'h30,'h1234, mk(0,0,1,0,0,1,1,'h30,'h1234));
        vecs[5]  = mkv(0,0,0,0,             0,0,0,0,        z);
        vecs[6]  = mkv(1,0,'h30,0,          0,0,0,0,        mk(1,0,0,0,0,1,0,'h30,0));
        vecs[7]  = mkv(1,0,'h30,0,          0,0,0,0,        mk(0,'h1234,0,0,0,0,0,0,0));
        vecs[8]  = mkv(0,0,0,0,             1,0,'h10,0,     mk(0,0,1,0,0,1,0,'h10,0));
        vecs[9]  = mkv(0,0,0,0,             0,0,0,0,        mk(0,0,0,1,'hDEADBEEF,0,0,0,0));
        vecs[10] = mkv(1,1,'h20,'h55,       1,0,'h30,0,     mk(0,0,0,0,0,1,1,'h20,'h55));
        vecs[11] = mkv(0,0,0,0,             1,0,'h30,0,     mk(0,0,1,0,0,1,0,'h30,0));
        vecs[12] = mkv(1,1,'h48,'h66,       0,0,0,0,        mk(1,0,0,1,'h1234,0,0,0,0));
        vecs[13] = mkv(1,1,'h48,'h66,       0,0,0,0,        mk(0,0,0,0,0,1,1,'h48,'h66));
        vecs[14] = mkv(0,0,0,0,             0,0,0,0,        z);

        drive(0,0,0,0,0,0,0,0);
        #12;
        check("reset_idle", z);
        @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].cen, vecs[i].cwr, vecs[i].caddr, vecs[i].cwd,
                  vecs[i].nreq, vecs[i].nwr, vecs[i].naddr, vecs[i].nwd);
            @(negedge clk);
            check($sformatf("vec%0d", i), vecs[i].exp);
            @(posedge clk);
            #1;
        end

        // CPU streams six stores while the NIC waits to read 0x20.
        s = 0;
        for (int c = 1; c <= 8; c++) begin
            logic        e_st;
            logic [31:0] e_a;
            logic [63:0] e_d;
            e_st = (c == 5) || (c == 6);
            e_a  = (c == 5) ? 32'h20 : (c == 6) ? 32'h0 : 32'h80 + 32'(8 * s);
            e_d  = (c == 5 || c == 6) ? 64'h0 : 64'(s + 1);
            drive(s < 6, 1, 32'h80 + 32'(8 * s), 64'(s + 1), c <= 5, 0, 'h20, 0);
            @(negedge clk);
            check($sformatf("starve_c%0d", c),
                  mk(e_st, 0, c == 5, c == 6, (c == 6) ? 64'h55 : 64'h0,
                     c != 6, (c != 5) && (c != 6), e_a, e_d));
            if (!e_st) s++;
            @(posedge clk);
            #1;
        end
        drive(0,0,0,0,0,0,0,0);
        @(negedge clk);
        check("starve_done_idle", z);
        @(posedge clk);
        #1;

        // Reset asserted while a CPU load is in its return cycle.
        drive(1,0,'h10,0,0,0,0,0);
        @(negedge clk);
        check("rst_seq_issue", mk(1,0,0,0,0,1,0,'h10,0));
        @(posedge clk);
        #1;
        check("rst_seq_cpu_ld", mk(0,'hDEADBEEF,0,0,0,0,0,0,0));
        reset = 1'b1;
        drive(1,0,'h10,0,1,0,'h30,0);
        #1;
        check("rst_async_zero", z);
        @(posedge clk);
        #1;
        check("rst_hold_zero", z);
        @(posedge clk);
        #1 reset = 1'b0;
        drive(0,0,0,0,0,0,0,0);
        @(negedge clk);
        check("rst_no_stale", z);
        @(posedge clk);
        #1;
        drive(1,1,'h50,'h77,0,0,0,0);
        @(negedge clk);
        check("post_rst_grant", mk(0,0,0,0,0,1,1,'h50,'h77));
        @(posedge clk);
        #1;
        drive(0,0,0,0,0,0,0,0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
